pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, program-counter width in bits (4..16).
REQ-002 SHALL have parameter STACK_DEPTH, default 4, return-address stack entries (1..16).
REQ-003 SHALL have parameter RESET_VEC, default 0, PC value loaded on reset (ADDR_W bits).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port stall  input  1  freeze all state this cycle, highest priority.
REQ-007 SHALL have port op  input  3  operation code (pc_pkg encoding).
REQ-008 SHALL have port target  input  ADDR_W  jump/branch/call destination, normally IR low bits.
REQ-009 SHALL have port cond  input  1  branch condition flag.
REQ-010 SHALL have port err_clr  input  1  clear sticky error flags.
REQ-011 SHALL have port PC_out  output  ADDR_W  current program counter, registered.
REQ-012 SHALL have port sp_out  output  clog2(STACK_DEPTH+1)  stack occupancy.
REQ-013 SHALL have port ovf  output  1  sticky stack-overflow flag.
REQ-014 SHALL have port unf  output  1  sticky stack-underflow flag.

Function
REQ-015 SHALL decode op: NOP=0 hold; INC=1 PC+1; JMP=2 PC<=target; BR=3 PC<=target if cond else PC+1; CALL=4 push PC+1, PC<=target; RET=5 PC<=pop; 6,7 treated as NOP.
REQ-016 SHALL, when stall=1, hold PC_out, stack, sp_out, ovf, unf regardless of op and err_clr.
REQ-017 SHALL compute all PC arithmetic modulo 2^ADDR_W (PC=all-ones + INC -> 0; CALL pushes 0 in that case).
REQ-018 SHALL apply each op with one-cycle latency: PC_out reflects the op on the clock edge that samples it.
REQ-019 SHALL, on CALL with sp_out=STACK_DEPTH, leave PC and stack unchanged and set ovf.
REQ-020 SHALL, on RET with sp_out=0, leave PC unchanged and set unf.
REQ-021 SHALL return the most recently pushed, not yet popped, address on RET (LIFO).
REQ-022 SHALL clear ovf/unf on err_clr=1 when no new error occurs that cycle; a new error in the same cycle SHALL win (flag stays 1).
REQ-023 SHALL keep stack contents unreadable except via RET; popped entries need not be cleared.

Reset
REQ-024 SHALL, on rst_n low at any time (including mid-call sequence), force PC_out=RESET_VEC, sp_out=0, ovf=0, unf=0 asynchronously.
REQ-025 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.
REQ-026 SHALL not require stack storage entries to be reset.

Structure
REQ-027 SHALL place op encodings (OP_NOP..OP_RET) and width helpers in shared package pc_pkg.
REQ-028 SHALL implement the return stack as sub-module pc_stack (push, pop, data in/out, count, full, empty), parametrised by ADDR_W and STACK_DEPTH.
REQ-029 SHALL keep all PC/op sequencing and error flags in pc_seq; pc_stack contains no error logic.

Verification
REQ-030 SHALL cover reset: RESET_VEC=8'h10, release rst_n, 3x INC -> PC_out 10,11,12,13; assert rst_n mid-run -> PC_out=10 immediately.
REQ-031 SHALL cover branch: PC=20, BR target=40 cond=0 -> 21; BR target=40 cond=1 -> 40; JMP 7F -> 7F; INC at FF -> 00.
REQ-032 SHALL cover nesting: PC=05, CALL 30, CALL 50, RET, RET -> PC 30, 50, 31, 06; sp_out 1,2,1,0.
REQ-033 SHALL cover overflow/underflow: STACK_DEPTH=4, five CALLs -> fifth holds PC, ovf=1, sp_out=4; RET at sp_out=0 -> unf=1, PC unchanged.
REQ-034 SHALL cover stall and err_clr: stall=1 with CALL -> no change; err_clr with simultaneous failing RET -> unf stays 1; err_clr alone -> flags 0.
REQ-035 SHALL rerun REQ-032 with ADDR_W=12, STACK_DEPTH=1 to check parametrisation (second CALL sets ovf).

Source files
------------

// File: rtl/pc_pkg.sv
// Shared op encodings and width helpers for the program-counter sequencer.
package pc_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_INC  = 3'd1,
        OP_JMP  = 3'd2,
        OP_BR   = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5
    } op_t;

    localparam int OP_W = 3;

    // Bits needed to count 0..depth inclusive (stack occupancy).
    function automatic int sp_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO; occupancy is the only reset state, storage is left as-is.
module pc_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    localparam int SP_W       = sp_w(STACK_DEPTH),
    localparam int IDX_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic [SP_W-1:0]   count,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [SP_W-1:0]   top;

    assign full  = (count == SP_W'(STACK_DEPTH));
    assign empty = (count == '0);
    assign top   = count - SP_W'(1);
    assign dout  = mem[top[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[count[IDX_W-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (push && !full)
            count <= count + SP_W'(1);
        else if (pop && !empty)
            count <= top;
    end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: op decode, call/return via pc_stack, sticky stack errors.
module pc_seq
    import pc_pkg::*;
#(
    parameter int              ADDR_W      = 8,
    parameter int              STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    localparam int             SP_W        = sp_w(STACK_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [OP_W-1:0]   op,
    input  logic [ADDR_W-1:0] target,
    input  logic              cond,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] PC_out,
    output logic [SP_W-1:0]   sp_out,
    output logic              ovf,
    output logic              unf
);

    op_t               op_e;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] ret_addr;
    logic              full, empty;
    logic              is_call, is_ret;
    logic              push, pop;
    logic              new_ovf, new_unf;

    assign op_e    = op_t'(op);
    assign pc_inc  = PC_out + ADDR_W'(1);
    assign is_call = !stall && (op_e == OP_CALL);
    assign is_ret  = !stall && (op_e == OP_RET);
    assign push    = is_call && !full;
    assign pop     = is_ret && !empty;
    assign new_ovf = is_call && full;
    assign new_unf = is_ret && empty;

    pc_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (ret_addr),
        .count (sp_out),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC_out <= RESET_VEC;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else if (!stall) begin
            unique case (op_e)
                OP_INC:  PC_out <= pc_inc;
                OP_JMP:  PC_out <= target;
                OP_BR:   PC_out <= cond ? target : pc_inc;
                OP_CALL: if (!full)  PC_out <= target;
                OP_RET:  if (!empty) PC_out <= ret_addr;
                default: PC_out <= PC_out;
            endcase
            // A fresh error in the same cycle as err_clr keeps the flag set.
            ovf <= new_ovf || (ovf && !err_clr);
            unf <= new_unf || (unf && !err_clr);
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: 8-bit/depth-4 instance and 12-bit/depth-1 instance.
module tb_pc_seq;
    import pc_pkg::*;

    typedef struct {
        string       tag;
        bit          which;
        logic [15:0] pc;
        int          sp;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        stall_a = 0, cond_a = 0, clr_a = 0;
    logic [2:0]  op_a = 0;
    logic [7:0]  tgt_a = 0;
    logic [7:0]  pc_a;
    logic [2:0]  sp_a;
    logic        ovf_a, unf_a;

    logic        stall_b = 0, cond_b = 0, clr_b = 0;
    logic [2:0]  op_b = 0;
    logic [11:0] tgt_b = 0;
    logic [11:0] pc_b;
    logic [0:0]  sp_b;
    logic        ovf_b, unf_b;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pc_seq #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_VEC(8'h10)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .stall(stall_a), .op(op_a), .target(tgt_a),
        .cond(cond_a), .err_clr(clr_a), .PC_out(pc_a), .sp_out(sp_a),
        .ovf(ovf_a), .unf(unf_a)
    );

    pc_seq #(.ADDR_W(12), .STACK_DEPTH(1), .RESET_VEC(12'h000)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .stall(stall_b), .op(op_b), .target(tgt_b),
        .cond(cond_b), .err_clr(clr_b), .PC_out(pc_b), .sp_out(sp_b),
        .ovf(ovf_b), .unf(unf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input exp_t e);
        if (!e.which) begin
            chk({e.tag, ".pc"},  32'(pc_a),  32'(e.pc));
            chk({e.tag, ".sp"},  32'(sp_a),  32'(e.sp));
            chk({e.tag, ".ovf"}, 32'(ovf_a), 32'(e.ovf));
            chk({e.tag, ".unf"}, 32'(unf_a), 32'(e.unf));
        end else begin
            chk({e.tag, ".pc"},  32'(pc_b),  32'(e.pc));
            chk({e.tag, ".sp"},  32'(sp_b),  32'(e.sp));
            chk({e.tag, ".ovf"}, 32'(ovf_b), 32'(e.ovf));
            chk({e.tag, ".unf"}, 32'(unf_b), 32'(e.unf));
        end
    endtask

    // Drive one op on the chosen instance, queue its expected result, then
    // pop and compare just after the sampling edge.
    task automatic step(input string tag, input bit which, input op_t op,
                        input logic [15:0] tgt, input logic c, input logic st,
                        input logic clr, input logic [15:0] epc, input int esp,
                        input logic eovf, input logic eunf);
        exp_t e;
        @(negedge clk);
        if (!which) begin
            op_a = op; tgt_a = tgt[7:0]; cond_a = c; stall_a = st; clr_a = clr;
        end else begin
            op_b = op; tgt_b = tgt[11:0]; cond_b = c; stall_b = st; clr_b = clr;
        end
        e.tag = tag; e.which = which; e.pc = epc; e.sp = esp; e.ovf = eovf; e.unf = eunf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk_state(e);
        end
        op_a = OP_NOP; stall_a = 0; clr_a = 0; cond_a = 0;
        op_b = OP_NOP; stall_b = 0; clr_b = 0; cond_b = 0;
    endtask

    task automatic chk_reset(input string tag);
        exp_t e;
        e.tag = tag; e.which = 0; e.pc = 16'h10; e.sp = 0; e.ovf = 0; e.unf = 0;
        chk_state(e);
        e.which = 1; e.pc = 16'h000;
        chk_state(e);
    endtask

    initial begin
        // reset state
        #12;
        chk_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;

        step("inc1", 0, OP_INC,  0, 0, 0, 0, 16'h11, 0, 0, 0);
        step("inc2", 0, OP_INC,  0, 0, 0, 0, 16'h12, 0, 0, 0);
        step("inc3", 0, OP_INC,  0, 0, 0, 0, 16'h13, 0, 0, 0);
        step("call_pre_rst", 0, OP_CALL, 16'h40, 0, 0, 0, 16'h40, 1, 0, 0);

        // asynchronous reset mid-call: visible without a clock edge
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;

        // branch / jump / wrap
        step("jmp20",  0, OP_JMP,  16'h20, 0, 0, 0, 16'h20, 0, 0, 0);
        step("br_nt",  0, OP_BR,   16'h40, 0, 0, 0, 16'h21, 0, 0, 0);
        step("br_t",   0, OP_BR,   16'h40, 1, 0, 0, 16'h40, 0, 0, 0);
        step("jmp7f",  0, OP_JMP,  16'h7F, 0, 0, 0, 16'h7F, 0, 0, 0);
        step("jmpff",  0, OP_JMP,  16'hFF, 0, 0, 0, 16'hFF, 0, 0, 0);
        step("inc_wr", 0, OP_INC,  0,      0, 0, 0, 16'h00, 0, 0, 0);
        step("jmpff2", 0, OP_JMP,  16'hFF, 0, 0, 0, 16'hFF, 0, 0, 0);
        step("call_wr",0, OP_CALL, 16'h30, 0, 0, 0, 16'h30, 1, 0, 0);
        step("ret_wr", 0, OP_RET,  0,      0, 0, 0, 16'h00, 0, 0, 0);
        step("op6",    0, op_t'(3'd6), 16'h55, 1, 0, 0, 16'h00, 0, 0, 0);
        step("op7",    0, op_t'(3'd7), 16'h55, 1, 0, 0, 16'h00, 0, 0, 0);

        // nesting
        step("jmp05",  0, OP_JMP,  16'h05, 0, 0, 0, 16'h05, 0, 0, 0);
        step("call30", 0, OP_CALL, 16'h30, 0, 0, 0, 16'h30, 1, 0, 0);
        step("call50", 0, OP_CALL, 16'h50, 0, 0, 0, 16'h50, 2, 0, 0);
        step("ret1",   0, OP_RET,  0,      0, 0, 0, 16'h31, 1, 0, 0);
        step("ret2",   0, OP_RET,  0,      0, 0, 0, 16'h06, 0, 0, 0);

        // overflow, stall, LIFO drain, underflow, err_clr
        step("c1",     0, OP_CALL, 16'h10, 0, 0, 0, 16'h10, 1, 0, 0);
        step("c2",     0, OP_CALL, 16'h20, 0, 0, 0, 16'h20, 2, 0, 0);
        step("c3",     0, OP_CALL, 16'h30, 0, 0, 0, 16'h30, 3, 0, 0);
        step("c4",     0, OP_CALL, 16'h40, 0, 0, 0, 16'h40, 4, 0, 0);
        step("c5_ovf", 0, OP_CALL, 16'h50, 0, 0, 0, 16'h40, 4, 1, 0);
        step("stall_call", 0, OP_CALL, 16'h60, 0, 1, 0, 16'h40, 4, 1, 0);
        step("stall_clr",  0, OP_RET,  0,      0, 1, 1, 16'h40, 4, 1, 0);
        step("clr_ovf_new",0, OP_CALL, 16'h70, 0, 0, 1, 16'h40, 4, 1, 0);
        step("r4",     0, OP_RET,  0, 0, 0, 0, 16'h31, 3, 1, 0);
        step("r3",     0, OP_RET,  0, 0, 0, 0, 16'h21, 2, 1, 0);
        step("r2",     0, OP_RET,  0, 0, 0, 0, 16'h11, 1, 1, 0);
        step("r1",     0, OP_RET,  0, 0, 0, 0, 16'h07, 0, 1, 0);
        step("r0_unf", 0, OP_RET,  0, 0, 0, 0, 16'h07, 0, 1, 1);
        step("clr_unf_new", 0, OP_RET, 0, 0, 0, 1, 16'h07, 0, 0, 1);
        step("clr",    0, OP_NOP,  0, 0, 0, 1, 16'h07, 0, 0, 0);

        // 12-bit, single-entry stack
        step("b_jmp",   1, OP_JMP,  16'h005, 0, 0, 0, 16'h005, 0, 0, 0);
        step("b_c1",    1, OP_CALL, 16'h030, 0, 0, 0, 16'h030, 1, 0, 0);
        step("b_c2ovf", 1, OP_CALL, 16'h050, 0, 0, 0, 16'h030, 1, 1, 0);
        step("b_r1",    1, OP_RET,  0,       0, 0, 0, 16'h006, 0, 1, 0);
        step("b_r0unf", 1, OP_RET,  0,       0, 0, 0, 16'h006, 0, 1, 1);
        step("b_jfff",  1, OP_JMP,  16'hFFF, 0, 0, 1, 16'hFFF, 0, 0, 0);
        step("b_incwr", 1, OP_INC,  0,       0, 0, 0, 16'h000, 0, 0, 0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
